// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit.
// Forward-select codes, the unused-source Tuse marker and stage Tnew values.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_GRF = 2'b00,
    FWD_E   = 2'b01,
    FWD_M   = 2'b10,
    FWD_W   = 2'b11
  } fwd_e;

  localparam logic [1:0] TUSE_NONE   = 2'b11;
  localparam logic [1:0] TNEW_NOW    = 2'd0;
  localparam logic [1:0] TNEW_LOAD_E = 2'd2;
  localparam logic [1:0] TNEW_LOAD_M = 2'd1;

endpackage

// File: rtl/md_busy_timer.sv
// Busy timer for the multi-cycle HI/LO unit.
// A start loads the op latency; the count then drains one per cycle.
module md_busy_timer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES,
  localparam int CW   = $clog2(MAXC + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          is_div,
  output logic          busy,
  output logic [CW-1:0] cnt
);

  localparam logic [CW-1:0] MUL_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);

  // A start always reloads, even over a running count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= is_div ? DIV_LD : MUL_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign busy = start | (cnt != '0);

endmodule

// File: rtl/hazard_ctrl_md.sv
// Hazard unit: Tuse/Tnew stalls, D-stage forward selects,
// HI/LO busy interlock and saturating stall counters.
module hazard_ctrl_md
  import hazard_pkg::*;
#(
  parameter int AW          = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [AW-1:0]    D_A1,
  input  logic [AW-1:0]    D_A2,
  input  logic [TW-1:0]    D_rs_Tuse,
  input  logic [TW-1:0]    D_rt_Tuse,
  input  logic             D_is_md,
  input  logic [AW-1:0]    E_A3,
  input  logic [AW-1:0]    M_A3,
  input  logic [AW-1:0]    W_A3,
  input  logic             E_RegWrite,
  input  logic             M_RegWrite,
  input  logic             W_RegWrite,
  input  logic [TW-1:0]    E_Tnew,
  input  logic [TW-1:0]    M_Tnew,
  input  logic             E_md_start,
  input  logic             E_md_is_div,
  input  logic             cnt_clr,
  output logic             stall,
  output logic             md_busy,
  output logic [1:0]       D_rs_fwd,
  output logic [1:0]       D_rt_fwd,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] md_stall_cnt
);

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int MCW  = $clog2(MAXC + 1);

  logic rs_e, rs_m, rs_w;
  logic rt_e, rt_m, rt_w;
  logic rs_stall, rt_stall;
  logic data_stall, md_stall;
  logic e_now, m_now;
  fwd_e rs_sel, rt_sel;
  logic [MCW-1:0] md_cnt_unused;

  // Register 0 is hard-wired, so it never matches a producer.
  assign rs_e = E_RegWrite & (D_A1 == E_A3) & (D_A1 != '0);
  assign rs_m = M_RegWrite & (D_A1 == M_A3) & (D_A1 != '0);
  assign rs_w = W_RegWrite & (D_A1 == W_A3) & (D_A1 != '0);
  assign rt_e = E_RegWrite & (D_A2 == E_A3) & (D_A2 != '0);
  assign rt_m = M_RegWrite & (D_A2 == M_A3) & (D_A2 != '0);
  assign rt_w = W_RegWrite & (D_A2 == W_A3) & (D_A2 != '0);

  assign rs_stall = (rs_e & (D_rs_Tuse < E_Tnew))
                  | (rs_m & (D_rs_Tuse < M_Tnew));
  assign rt_stall = (rt_e & (D_rt_Tuse < E_Tnew))
                  | (rt_m & (D_rt_Tuse < M_Tnew));

  assign e_now = (E_Tnew == '0);
  assign m_now = (M_Tnew == '0);

  // Nearest producer wins; if not ready, do not fall through.
  always_comb begin
    rs_sel = FWD_GRF;
    if (rs_e) begin
      rs_sel = e_now ? FWD_E : FWD_GRF;
    end else if (rs_m) begin
      rs_sel = m_now ? FWD_M : FWD_GRF;
    end else if (rs_w) begin
      rs_sel = FWD_W;
    end
  end

  always_comb begin
    rt_sel = FWD_GRF;
    if (rt_e) begin
      rt_sel = e_now ? FWD_E : FWD_GRF;
    end else if (rt_m) begin
      rt_sel = m_now ? FWD_M : FWD_GRF;
    end else if (rt_w) begin
      rt_sel = FWD_W;
    end
  end

  assign D_rs_fwd = rs_sel;
  assign D_rt_fwd = rt_sel;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (E_md_start),
    .is_div  (E_md_is_div),
    .busy    (md_busy),
    .cnt     (md_cnt_unused)
  );

  assign data_stall = rs_stall | rt_stall;
  assign md_stall   = D_is_md & md_busy;
  assign stall      = data_stall | md_stall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (md_stall && (md_stall_cnt != '1))
        md_stall_cnt <= md_stall_cnt + CNT_W'(1);
    end
  end

endmodule
